// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the multiply/divide unit: operand handshake,
// result handshake, flush and busy.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic            busy;

    modport master (
        output in_valid, in_op, in_rs1, in_rs2, flush, out_ready,
        input  in_ready, out_valid, out_result, busy
    );

    modport slave (
        input  in_valid, in_op, in_rs1, in_rs2, flush, out_ready,
        output in_ready, out_valid, out_result, busy
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide,
// XLEN iterations. Define MULDIV_FAST_MUL_EN for a single-cycle multiplier.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [2:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q, acc_n;
    logic [XLEN-1:0]   res_q;

    logic              accept, is_div, sgn_a, sgn_b, s_a, s_b, neg_in;
    logic              div_zero, div_ovf, fast, direct;
    logic [XLEN-1:0]   mag_a, mag_b, special_res;
    logic [2*XLEN-1:0] fast_prod;

    // Sign fix and output select, shared by the iterative and direct paths.
    function automatic logic [XLEN-1:0] finish(input logic [2:0] op, input logic neg,
                                               input logic [2*XLEN-1:0] acc);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   h;
        if (!op[2]) begin
            p = neg ? -acc : acc;
            return (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        end
        h = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        return neg ? -h : h;
    endfunction

    always_comb begin
        accept   = (state_q == S_IDLE) && bus.in_valid && !bus.flush;
        is_div   = bus.in_op[2];
        sgn_a    = (bus.in_op == 3'b001) || (bus.in_op == 3'b010) ||
                   (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
        sgn_b    = (bus.in_op == 3'b001) || (bus.in_op == 3'b100) || (bus.in_op == 3'b110);
        s_a      = sgn_a && bus.in_rs1[XLEN-1];
        s_b      = sgn_b && bus.in_rs2[XLEN-1];
        mag_a    = s_a ? -bus.in_rs1 : bus.in_rs1;
        mag_b    = s_b ? -bus.in_rs2 : bus.in_rs2;
        // Remainder takes the dividend's sign; everything else is sA^sB.
        neg_in   = (is_div && bus.in_op[1]) ? s_a : (s_a ^ s_b);
        div_zero = is_div && (bus.in_rs2 == '0);
        div_ovf  = is_div && !bus.in_op[0] &&
                   (bus.in_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (bus.in_rs2 == '1);
        if (div_zero) special_res = bus.in_op[1] ? bus.in_rs1 : '1;
        else          special_res = bus.in_op[1] ? '0 : bus.in_rs1;
`ifdef MULDIV_FAST_MUL_EN
        fast      = !is_div;
        fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
`else
        fast      = 1'b0;
        fast_prod = '0;
`endif
        direct   = div_zero || div_ovf || fast;
    end

    // One iteration: multiply adds opnd into the high half then shifts right;
    // divide shifts the dividend into the remainder and trial-subtracts opnd.
    logic [XLEN:0] sum, part, diff;
    always_comb begin
        sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : {XLEN{1'b0}})};
        part = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff = part - {1'b0, opnd_q};
        if (!op_q[2])      acc_n = {sum, acc_q[XLEN-1:1]};
        else if (!diff[XLEN]) acc_n = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else               acc_n = {part[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = direct ? S_DONE : S_CALC;
            S_CALC: if (cnt_q == '0) state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (bus.flush) state_d = S_IDLE;
    end

    always_comb begin
        bus.in_ready  = (state_q == S_IDLE);
        bus.out_valid = (state_q == S_DONE);
        bus.busy      = (state_q != S_IDLE);
    end

    assign bus.out_result = res_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opnd_q <= '0;
            acc_q  <= '0;
            res_q  <= '0;
        end else if (accept) begin
            cnt_q  <= CW'(XLEN-1);
            op_q   <= bus.in_op;
            neg_q  <= neg_in;
            opnd_q <= is_div ? mag_b : mag_a;
            acc_q  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
            if (div_zero || div_ovf) res_q <= special_res;
            else if (fast)           res_q <= finish(bus.in_op, neg_in, fast_prod);
        end else if (state_q == S_CALC && !bus.flush) begin
            acc_q <= acc_n;
            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
            else             res_q <= finish(op_q, neg_q, acc_n);
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Random and directed checks of muldiv_unit against an arithmetic RV32M model.
module tb_muldiv_unit;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(XLEN)) bus();
    muldiv_unit #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa = longint'($signed(a));
        longint sb = longint'($signed(b));
        longint ua = longint'({32'b0, a});
        longint ub = longint'({32'b0, b});
        longint p;
        logic ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: p = ua * ub;
            3'd1: begin p = sa * sb; p = p >>> 32; end
            3'd2: begin p = sa * ub; p = p >>> 32; end
            3'd3: begin p = ua * ub; p = p >> 32; end
            3'd4: p = (b == 0) ? -1 : ovf ? ua : sa / sb;
            3'd5: p = (b == 0) ? -1 : ua / ub;
            3'd6: p = (b == 0) ? ua : ovf ? 0 : sa % sb;
            default: p = (b == 0) ? ua : ua % ub;
        endcase
        return p[31:0];
    endfunction

    function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b);
        if (op[2]) begin
            if (b == 0) return 1;
            if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return XLEN + 1;
        end
`ifdef MULDIV_FAST_MUL_EN
        return 1;
`else
        return XLEN + 1;
`endif
    endfunction

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic [31:0] e;
        e = ref_res(op, a, b);
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.in_op = op; bus.in_rs1 = a; bus.in_rs2 = b;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk($sformatf("result op%0d %h,%h", op, a, b), bus.out_result, e);
        chk($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat(op, a, b)));
        @(negedge clk);
        chk("in_ready_after_consume", 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        bit seen;
        logic [31:0] held, a, b;
        logic [2:0] op;
        bus.in_valid = 1'b0; bus.in_op = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
        bus.flush = 1'b0; bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        rst_n = 1'b1;

        do_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        chk("mul_7_neg3", bus.out_result, 32'hFFFF_FFEB);
        do_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        do_op(3'd3, 32'h8000_0000, 32'h8000_0000);
        do_op(3'd2, 32'hFFFF_FFFF, 32'h0000_0002);
        do_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        do_op(3'd5, 32'd100, 32'd7);
        do_op(3'd7, 32'd100, 32'd7);
        do_op(3'd5, 32'h1234, 32'd0);
        do_op(3'd6, 32'h1234, 32'd0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

        // Backpressure in DONE
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd5; bus.in_rs1 = 32'd100; bus.in_rs2 = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 100 && !bus.out_valid; i++) @(negedge clk);
        held = bus.out_result;
        chk("bp_result", held, 32'd14);
        for (int i = 0; i < 5; i++) begin
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stable", bus.out_result, 32'd14);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);

        // Asynchronous reset mid-CALC
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_rs1 = 32'd1000; bus.in_rs2 = 32'd3;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_busy", 32'(bus.busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_out_result", bus.out_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Flush of a DIV at k+10
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_op = 3'd4; bus.in_rs1 = 32'd100; bus.in_rs2 = 32'd7;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        chk("flush_busy", 32'(bus.busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("flush_no_out_valid", 32'(seen), 32'd0);

        // Request together with flush is dropped
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        bus.in_op = 3'd5; bus.in_rs1 = 32'h1234; bus.in_rs2 = 32'd0;
        @(negedge clk);
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        chk("flush_req_busy", 32'(bus.busy), 32'd0);
        chk("flush_req_out_valid", 32'(bus.out_valid), 32'd0);
        do_op(3'd7, 32'd100, 32'd7);

        for (int n = 0; n < 60; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 300);
                4: b = -$urandom_range(1, 15);
                default: ;
            endcase
            do_op(op, a, b);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide execute unit implementing the RV32M operation set, parametrised in datapath width. Sits beside the single-cycle ALU in the execute stage and is selected by the decoder for OP instructions with funct7 = 0000001. Operands are accepted through a valid/ready handshake. The result is held under valid/ready backpressure until writeback consumes it. An in-flight operation can be killed by a pipeline flush.

## Interface
- XLEN, 32, datapath width; even, ≥ 8.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  3  RV32M funct3:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- in_rs1  in  XLEN  operand A (dividend / multiplicand).
- in_rs2  in  XLEN  operand B (divisor / multiplier).
- flush  in  1  abort current operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- busy  out  1  high in CALC or DONE.

## Operation
- States: IDLE, CALC, DONE.
- Reset values: state IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, counter=0.
- IDLE:
  - in_ready=1.
  - On in_valid & ~flush, latch op and operands.
  - Normally go to CALC with counter=XLEN-1.
  - Special cases go directly to DONE (see below).
- Sign preparation at accept:
  - DIV/REM/MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - All other ops: unsigned.
  - Take magnitudes and record result sign: product sign = sA^sB; quotient sign = sA^sB; remainder sign = sA.
- CALC:
  - One iteration per cycle.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each cycle; exit to DONE when counter==0, after XLEN iterations.
- DONE:
  - Apply the sign fix (two's-complement negate if the recorded sign is set).
  - Select the output: MUL → low XLEN; MULH* → high XLEN; DIV* → quotient; REM* → remainder.
  - Hold out_valid=1 and a stable out_result until out_ready, then go to IDLE.
- Special cases, resolved at accept with no CALC:
  - Divisor zero: quotient = all ones; remainder = rs1 unmodified.
  - Signed overflow (DIV/REM, rs1 = 1 followed by XLEN-1 zeros, rs2 = all ones): quotient = rs1; remainder = 0.
- flush:
  - Highest priority, from any state: next state IDLE and out_valid=0 from the next cycle.
  - A request presented in the same cycle as flush is not accepted.
- in_valid while not IDLE is ignored; in_ready=0.

## Timing
- Accept at edge k (in_valid & in_ready).
- Iterative op: CALC spans cycles k+1 … k+XLEN; out_valid=1 from cycle k+XLEN+1. Latency is XLEN+1 cycles.
- Special case: out_valid=1 at cycle k+1.
- Result consumed at edge m (out_valid & out_ready): in_ready=1 in cycle m+1. Minimum issue interval is latency+1.
- out_result is registered and changes only on entry to DONE.
- busy = (state != IDLE).
- Reset asserted mid-operation returns all outputs to their reset values immediately, asynchronously.

## Configuration
- MULDIV_FAST_MUL_EN:
  - Defined: MUL/MULH/MULHSU/MULHU use a single-cycle combinational XLEN×XLEN multiplier and go IDLE→DONE with out_valid at k+1. Divides are unchanged.
  - Undefined: multiplies use the iterative CALC path at XLEN+1 latency.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → out_result 0xFFFFFFEB. out_valid at k+33, or k+1 with MULDIV_FAST_MUL_EN.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU same operands → 0x40000000; MULHSU 0xFFFFFFFF × 0x00000002 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD; REM same → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU → 2.
- DIVU 0x1234 / 0 → 0xFFFFFFFF and REM 0x1234 / 0 → 0x1234, both at k+1. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_result stable, in_ready=0. Release → in_ready=1 next cycle.
- Flush at k+10 of a DIV → out_valid never asserts, in_ready=1 at k+11. A new request with flush high is not accepted. rst_n low mid-CALC → outputs at their reset values immediately.
